// File: rtl/bcd_led_scan.sv
// bcd_led_scan: four-digit multiplexed common-anode 7-segment driver.
// Takes the packed BCD result of the binary-to-decimal converter. A new value
// is held pending and only reaches the display at a frame boundary, so a frame
// never shows a mix of old and new digits.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits 3..1).
module bcd_led_scan #(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter logic [3:0]  GUARD    = 4'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        ld,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [1:0]  dig_ptr,
    output logic        frame
);

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    logic [15:0] cnt;
    logic        tick;
    logic        boundary;

    logic [15:0] disp_bcd;
    logic [3:0]  disp_dp;
    logic [15:0] pend_bcd;
    logic [3:0]  pend_dp;
    logic        pend;

    logic [3:0]  cur_nib;
    logic        cur_dp_req;
    logic [3:0]  blank;
    logic        cur_blank;
    logic        in_guard;

    logic [6:0]  seg_next;
    logic [3:0]  an_next;
    logic        dp_next;

    // Active-low decode of one BCD nibble; anything above 9 shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign tick     = ce & (cnt == (SCAN_DIV - 16'd1));
    assign boundary = tick & (dig_ptr == 2'd0);
    assign frame    = boundary;

    // Slot prescaler: counts enabled cycles within a digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ce) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Digit pointer: descends 3,2,1,0 and wraps back to 3 at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_ptr <= 2'd3;
        end else if (tick) begin
            dig_ptr <= dig_ptr - 2'd1;
        end
    end

    // Pending/display registers. A load on the boundary cycle goes straight to
    // the display, otherwise it waits in the pending slot (last write wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bcd <= '0;
            disp_dp  <= '0;
            pend_bcd <= '0;
            pend_dp  <= '0;
            pend     <= 1'b0;
        end else if (boundary) begin
            if (ld) begin
                disp_bcd <= bcd_in;
                disp_dp  <= dp_in;
            end else if (pend) begin
                disp_bcd <= pend_bcd;
                disp_dp  <= pend_dp;
            end
            pend <= 1'b0;
        end else if (ld && ce) begin
            pend_bcd <= bcd_in;
            pend_dp  <= dp_in;
            pend     <= 1'b1;
        end
    end

    // Select the nibble and dp request of the digit being scanned.
    always_comb begin
        cur_nib    = disp_bcd[3:0];
        cur_dp_req = disp_dp[0];
        case (dig_ptr)
            2'd3: begin
                cur_nib    = disp_bcd[15:12];
                cur_dp_req = disp_dp[3];
            end
            2'd2: begin
                cur_nib    = disp_bcd[11:8];
                cur_dp_req = disp_dp[2];
            end
            2'd1: begin
                cur_nib    = disp_bcd[7:4];
                cur_dp_req = disp_dp[1];
            end
            default: begin
                cur_nib    = disp_bcd[3:0];
                cur_dp_req = disp_dp[0];
            end
        endcase
    end

    // Blanking mask: a digit is blanked only when it and every more
    // significant digit are zero with no dp request; digit 0 always shows.
    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        blank[3] = (disp_bcd[15:12] == 4'd0) & ~disp_dp[3];
        blank[2] = blank[3] & (disp_bcd[11:8] == 4'd0) & ~disp_dp[2];
        blank[1] = blank[2] & (disp_bcd[7:4] == 4'd0) & ~disp_dp[1];
        blank[0] = 1'b0;
`endif
    end

    // Next pin values for the current slot, guard window and blanking applied.
    always_comb begin
        cur_blank = blank[dig_ptr];
        in_guard  = (cnt < {12'd0, GUARD});
        seg_next  = cur_blank ? SEG_OFF : seg_decode(cur_nib);
        dp_next   = cur_blank ? 1'b1 : ~cur_dp_req;
        an_next   = ~(4'b0001 << dig_ptr);
        if (in_guard || cur_blank) begin
            an_next = '1;
        end
    end

    // Output registers: pins follow the scan state one enabled cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            dp  <= 1'b1;
            an  <= '1;
        end else if (ce) begin
            seg <= seg_next;
            dp  <= dp_next;
            an  <= an_next;
        end
    end

endmodule

// File: tb/tb_bcd_led_scan.sv
// tb_bcd_led_scan: directed bench for bcd_led_scan with SCAN_DIV=8, GUARD=2.
// Expectations follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_bcd_led_scan;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        ld;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  dig_ptr;
    logic        frame;

    int pass_cnt = 0;
    int fail_cnt = 0;

    bcd_led_scan #(
        .SCAN_DIV (16'd8),
        .GUARD    (4'd2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .bcd_in  (bcd_in),
        .dp_in   (dp_in),
        .ld      (ld),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .dig_ptr (dig_ptr),
        .frame   (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        assert (obs === expv) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Advance until the boundary cycle is showing (bounded).
    task automatic wait_frame();
        int n;
        n = 0;
        while (frame !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("frame_found", {15'd0, frame}, 16'd1);
    endtask

    // Scan one whole frame starting from the boundary cycle.
    // segs = {s3,s2,s1,s0}; lit = digits whose anode is driven; dps = dp pin per digit.
    task automatic scan_frame(input logic [27:0] segs, input logic [3:0] lit, input logic [3:0] dps);
        int d;
        int rel;
        logic [3:0] exp_an;
        logic [27:0] sv;
        wait_frame();
        sv = segs;
        for (int m = 1; m <= 28; m++) begin
            step();
            ld = 1'b0;
            if (m == 1) chk("frame_pulse_len", {15'd0, frame}, 16'd0);
            chk("dig_ptr_seq", {14'd0, dig_ptr}, 16'(3 - (m - 1) / 8));
            if (m >= 2) begin
                d   = 3 - (m - 2) / 8;
                rel = (m - 2) % 8;
                if (rel < 2 || !lit[d]) exp_an = 4'hF;
                else                     exp_an = ~(4'b0001 << d);
                chk("an_slot", {12'd0, an}, {12'd0, exp_an});
                if (rel == 2) begin
                    chk("seg_digit", {9'd0, seg}, {9'd0, sv[d*7 +: 7]});
                    chk("dp_digit", {15'd0, dp}, {15'd0, dps[d]});
                end
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ce     = 1'b1;
        ld     = 1'b0;
        bcd_in = 16'h0000;
        dp_in  = 4'h0;

        // Reset values
        step();
        step();
        chk("rst_seg", {9'd0, seg}, 16'h007F);
        chk("rst_dp", {15'd0, dp}, 16'd1);
        chk("rst_an", {12'd0, an}, 16'h000F);
        chk("rst_dig_ptr", {14'd0, dig_ptr}, 16'd3);
        chk("rst_frame", {15'd0, frame}, 16'd0);

        // Run into the digit-2 slot, then reset asynchronously mid-cycle
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) step();
        chk("pre_rst_dig_ptr", {14'd0, dig_ptr}, 16'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", {12'd0, an}, 16'h000F);
        chk("async_rst_seg", {9'd0, seg}, 16'h007F);
        chk("async_rst_dp", {15'd0, dp}, 16'd1);
        chk("async_rst_dig_ptr", {14'd0, dig_ptr}, 16'd3);
        step();
        rst_n = 1'b1;

        // First digit-3 slot after release
        step();
        step();
        chk("post_rst_guard_an", {12'd0, an}, 16'h000F);
        step();
`ifdef LEADING_ZERO_BLANK_EN
        chk("post_rst_seg", {9'd0, seg}, 16'h007F);
        chk("post_rst_an", {12'd0, an}, 16'h000F);
`else
        chk("post_rst_seg", {9'd0, seg}, 16'h0040);
        chk("post_rst_an", {12'd0, an}, 16'h0007);
`endif

        // Load/latch: 0x0255 latched, later 0x9999 without ld is ignored
        ld     = 1'b1;
        bcd_in = 16'h0255;
        dp_in  = 4'h0;
        step();
        ld     = 1'b0;
        bcd_in = 16'h9999;
`ifdef LEADING_ZERO_BLANK_EN
        scan_frame({7'h7F, 7'h24, 7'h12, 7'h12}, 4'b0111, 4'b1111);
`else
        scan_frame({7'h40, 7'h24, 7'h12, 7'h12}, 4'b1111, 4'b1111);
`endif

        // Boundary bypass: 0x0008 pending, overwritten by 0x1234 on the boundary
        step();
        step();
        ld     = 1'b1;
        bcd_in = 16'h0008;
        step();
        ld     = 1'b0;
        step();
        chk("boundary_frame", {15'd0, frame}, 16'd1);
        ld     = 1'b1;
        bcd_in = 16'h1234;
        scan_frame({7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b1111);

        // Invalid BCD nibbles and a dp request on digit 2
        ld     = 1'b1;
        bcd_in = 16'hA0F3;
        dp_in  = 4'b0100;
        step();
        ld     = 1'b0;
        scan_frame({7'h3F, 7'h40, 7'h3F, 7'h30}, 4'b1111, 4'b1011);

        // ce=0 for 20 cycles inside the digit-0 slot freezes everything
        ce = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("ce_hold_dig_ptr", {14'd0, dig_ptr}, 16'd0);
            chk("ce_hold_seg", {9'd0, seg}, 16'h0030);
            chk("ce_hold_an", {12'd0, an}, 16'h000E);
            chk("ce_hold_frame", {15'd0, frame}, 16'd0);
        end
        ce = 1'b1;
        step();
        step();
        step();
        chk("ce_resume_no_frame", {15'd0, frame}, 16'd0);
        chk("ce_resume_seg", {9'd0, seg}, 16'h0030);
        step();
        chk("ce_resume_frame", {15'd0, frame}, 16'd1);

        // All-zero value, loaded via bypass on this boundary
        ld     = 1'b1;
        bcd_in = 16'h0000;
        dp_in  = 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
        scan_frame({7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 4'b1111);
`else
        scan_frame({7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111, 4'b1111);
`endif

        // 0x0007 with dp on digit 1: the dp request stops blanking at digit 1
        ld     = 1'b1;
        bcd_in = 16'h0007;
        dp_in  = 4'b0010;
        step();
        ld     = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        scan_frame({7'h7F, 7'h7F, 7'h40, 7'h78}, 4'b0011, 4'b1101);
`else
        scan_frame({7'h40, 7'h40, 7'h40, 7'h78}, 4'b1111, 4'b1101);
`endif

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule

// File: doc/bcd_led_scan.md
# bcd_led_scan

Four-digit multiplexed 7-segment display driver that consumes the packed BCD result of the binary-to-decimal converter and scans it onto a common-anode LED module. Sits directly downstream of the converter: its load strobe is the converter's conversion-done pulse, and its BCD input is the converter's 16-bit decimal output. Holds the displayed value stable across whole scan frames, so updates never tear mid-frame.

## Interface
- SCAN_DIV, 16'd50000: enabled clock cycles per digit slot (≥ GUARD+2).
- GUARD, 4'd2: enabled cycles at the start of each slot with all anodes off (ghosting guard).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; all state advances only when ce=1.
- bcd_in  in  16  packed BCD digits; [15:12] = digit 3 (most significant) … [3:0] = digit 0.
- dp_in  in  4  decimal-point request per digit, bit i = digit i.
- ld  in  1  load strobe (connects to the converter's done pulse); sampled when ce=1.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  digit anodes, active-low, bit i = digit i.
- dig_ptr  out  2  digit currently being scanned.
- frame  out  1  one-cycle pulse at each frame boundary.

## Operation
- Prescaler cnt counts 0..SCAN_DIV-1 on ce and wraps; tick = ce & (cnt==SCAN_DIV-1).
- On tick, dig_ptr decrements 3→2→1→0→3 (same descending order as the converter's digit pointer).
- Frame boundary = tick with dig_ptr==0. On the boundary: frame=1 for that cycle; if pend=1, disp_bcd/disp_dp ← pend_bcd/pend_dp and pend ← 0.
- ld & ce: pend_bcd ← bcd_in, pend_dp ← dp_in, pend ← 1. A later ld before the boundary overwrites the pending value (last write wins).
- ld on the boundary cycle: the display registers take bcd_in/dp_in directly (bypass) and pend ← 0.
- Decode of disp nibble at dig_ptr (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex); nibble >9 → 3F ("-").
- an = ~(1<<dig_ptr), except all ones during the guard window or when the digit is blanked. dp = ~disp_dp[dig_ptr], forced to 1 when the digit is blanked.
- Reset values: cnt=0, dig_ptr=3, disp_bcd=0, disp_dp=0, pend=0, seg=7F, dp=1, an=F, frame=0.
- ce=0: all registers hold, including outputs.
- rst_n low at any time clears everything immediately, including any pending value.

## Timing
- seg/dp/an are registered: they reflect the dig_ptr/cnt state of the previous edge. The slot therefore appears at the pins 1 cycle after dig_ptr changes.
- Guard: an=F for the registered cycles where cnt<GUARD, then the digit is driven for SCAN_DIV-GUARD cycles.
- Latency from ld to visible value: up to 4·SCAN_DIV+1 enabled cycles; at least 1 (bypass case).
- frame is a combinational function of registered state, valid in the boundary cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits 3..1 are blanked (an bit high, seg=7F, dp=1) while they and every more-significant digit are 0 and have no dp request.
  - Digit 0 is never blanked.
  - Example: 0007 shows "   7".
- Undefined: all four digits are always driven; 0007 shows "0007".

## Test plan
(SCAN_DIV=8, GUARD=2, ce=1 unless stated.)
- Reset: rst_n=0 mid-scan → same cycle an=F, seg=7F, dp=1, dig_ptr=3; after release, the first digit-3 slot shows seg=40 (or blank with the macro).
- Load/latch: ld with bcd_in=0x0255, then bcd_in changed to 0x9999 without ld → next frame shows 0,2,5,5 (macro: blank,2,5,5). 0x9999 never appears.
- Boundary bypass: ld with 0x1234 exactly on the frame-boundary cycle → the following digit-3 slot shows seg=79. ld two cycles earlier with 0x0008 is overwritten.
- Invalid BCD and dp: bcd_in=0xA0F3, dp_in=4'b0100 → digit 3 seg=3F, digit 2 seg=40 with dp=0, digit 1 seg=3F, digit 0 seg=30.
- Guard and ce: each slot shows an=F for exactly 2 cycles then the active-low one-hot for 6. Holding ce=0 for 20 cycles mid-slot freezes cnt, dig_ptr, seg and an.
- Blanking macro: bcd_in=0x0000 → only an[0] ever asserted with seg=40. Without the macro, all four anodes cycle showing 40.
